// File: rtl/mips_const_ext_pipe.sv
// MIPS constant extension unit with a registered valid/ready output stage.
// A one-entry skid register lets in_ready come straight from a flop, with no path from out_ready.
module mips_const_ext_pipe #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [IN_W-1:0]  in_const,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_const,
  output logic [1:0]       out_mode
);

  if (OUT_W < IN_W + SHIFT) begin : g_param_check
    $error("mips_const_ext_pipe: OUT_W must be >= IN_W + SHIFT");
  end

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;

  logic             m_valid;
  logic [1:0]       m_mode;
  logic [OUT_W-1:0] m_const;
  logic             s_valid;
  logic [1:0]       s_mode;
  logic [OUT_W-1:0] s_const;

  logic             accept;
  logic             pop;

  assign zext = OUT_W'(in_const);
  assign sext = OUT_W'($signed(in_const));

  always_comb begin
    ext = zext;
    case (in_mode)
      2'd0:    ext = zext;
      2'd1:    ext = sext;
      2'd2:    ext = zext << (OUT_W - IN_W);
      2'd3:    ext = sext << SHIFT;
      default: ext = zext;
    endcase
  end

  assign in_ready  = !s_valid;
  assign accept    = in_valid && !s_valid;
  assign pop       = m_valid && out_ready;

  assign out_valid = m_valid;
  assign out_const = m_const;
  assign out_mode  = m_mode;

  // M empties or drains this cycle: refill from S first to keep FIFO order, else from input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_mode  <= '0;
      m_const <= '0;
      s_valid <= 1'b0;
      s_mode  <= '0;
      s_const <= '0;
    end else if (!m_valid || pop) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_mode  <= s_mode;
        m_const <= s_const;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_mode  <= in_mode;
        m_const <= ext;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_mode  <= in_mode;
      s_const <= ext;
    end
  end

endmodule

// File: tb/tb_mips_const_ext_pipe.sv
// Directed and randomized bench for mips_const_ext_pipe at IN_W=15, OUT_W=32, SHIFT=2.
module tb_mips_const_ext_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [14:0] in_const;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_const;
  logic [1:0]  out_mode;

  int checks;
  int failures;

  mips_const_ext_pipe #(.IN_W(15), .OUT_W(32), .SHIFT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_const  (in_const),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_const (out_const),
    .out_mode  (out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written reference for the fixed 15->32 bit, shift-2 configuration.
  function automatic logic [31:0] exp_const(input logic [1:0] m, input logic [14:0] c);
    case (m)
      2'd0:    return {17'b0, c};
      2'd1:    return {{17{c[14]}}, c};
      2'd2:    return {c, 17'b0};
      default: return {{15{c[14]}}, c, 2'b00};
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_const !== 32'h0 || out_mode !== 2'd0) begin
      failures++;
      $display("FAIL reset_during: out_valid=%b in_ready=%b out_const=%h out_mode=%0d required 0 1 00000000 0",
               out_valid, in_ready, out_const, out_mode);
    end
    #8 rst = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_const !== 32'h0 || out_mode !== 2'd0) begin
      failures++;
      $display("FAIL reset_after: out_valid=%b in_ready=%b out_const=%h out_mode=%0d required 0 1 00000000 0",
               out_valid, in_ready, out_const, out_mode);
    end
  endtask

  task automatic test_modes;
    logic [31:0] expv [4];
    expv[0] = 32'h00004001;
    expv[1] = 32'hFFFFC001;
    expv[2] = 32'h80020000;
    expv[3] = 32'hFFFF0004;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1;
      in_mode  = 2'(m);
      in_const = 15'h4001;
      tick;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_const !== expv[m] || out_mode !== 2'(m)) begin
        failures++;
        $display("FAIL mode_sweep m=%0d: valid=%b const=%h mode=%0d required 1 %h %0d",
                 m, out_valid, out_const, out_mode, expv[m], m);
      end
      tick;
    end
  endtask

  task automatic test_positive;
    logic [31:0] expv [2];
    logic [1:0]  mv   [2];
    expv[0] = 32'h00001234; mv[0] = 2'd1;
    expv[1] = 32'h000048D0; mv[1] = 2'd3;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_mode  = mv[k];
      in_const = 15'h1234;
      tick;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_const !== expv[k]) begin
        failures++;
        $display("FAIL positive_mode%0d: valid=%b const=%h required 1 %h", mv[k], out_valid, out_const, expv[k]);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_const  = 15'h0001;
    tick;
    in_const  = 15'h0002;
    tick;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_const !== 32'h1) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b out_const=%h required 0 1 00000001", in_ready, out_valid, out_const);
    end
    tick;
    checks++;
    if (in_ready !== 1'b0 || out_const !== 32'h1) begin
      failures++;
      $display("FAIL bp_hold: in_ready=%b out_const=%h required 0 00000001", in_ready, out_const);
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_const !== 32'h2) begin
      failures++;
      $display("FAIL bp_drain1: in_ready=%b out_valid=%b out_const=%h required 1 1 00000002", in_ready, out_valid, out_const);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain2: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] cv;
    logic [1:0]  mv;
    out_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) begin
        in_valid = 1'b1;
        in_mode  = 2'(i % 4);
        in_const = 15'(i * 331 + 7);
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_ready i=%0d: in_ready=%b required 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 1) begin
        mv = 2'((i - 1) % 4);
        cv = 15'((i - 1) * 331 + 7);
        checks++;
        if (out_valid !== 1'b1 || out_const !== exp_const(mv, cv) || out_mode !== mv) begin
          failures++;
          $display("FAIL stream_out i=%0d: valid=%b const=%h mode=%0d required 1 %h %0d",
                   i - 1, out_valid, out_const, out_mode, exp_const(mv, cv), mv);
        end
      end
      tick;
    end
  endtask

  task automatic test_random;
    logic [33:0] q[$];
    logic [33:0] held;
    logic        stall;
    int          sent;
    int          recv;
    int          cyc;
    int          n;
    n     = 10000;
    sent  = 0;
    recv  = 0;
    cyc   = 0;
    stall = 1'b0;
    held  = '0;
    while (recv < n && cyc < 60000) begin
      in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_const  = 15'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || {out_mode, out_const} !== held) begin
          failures++;
          $display("FAIL rand_stall cyc=%0d: valid=%b data=%h required 1 %h", cyc, out_valid, {out_mode, out_const}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        recv++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra cyc=%0d: data=%h required no output", cyc, {out_mode, out_const});
        end else begin
          if ({out_mode, out_const} !== q[0]) begin
            failures++;
            $display("FAIL rand_order cyc=%0d: data=%h required %h", cyc, {out_mode, out_const}, q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({in_mode, exp_const(in_mode, in_const)});
        sent++;
      end
      stall = out_valid && !out_ready;
      held  = {out_mode, out_const};
      tick;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != n || q.size() != 0) begin
      failures++;
      $display("FAIL rand_complete: received=%0d pending=%0d required %0d 0", recv, q.size(), n);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd1;
    in_const  = 15'h5555;
    tick;
    tick;
    in_valid  = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_const !== 32'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: out_valid=%b out_const=%h in_ready=%b required 0 00000000 1", out_valid, out_const, in_ready);
    end
    #3 rst = 1'b0;
    tick;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'd3;
    in_const  = 15'h2000;
    tick;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_const !== 32'h00008000 || out_mode !== 2'd3) begin
      failures++;
      $display("FAIL post_reset_txn: valid=%b const=%h mode=%0d required 1 00008000 3", out_valid, out_const, out_mode);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_const  = '0;
    out_ready = 1'b0;
    #15;
    test_reset;
    test_modes;
    test_positive;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
